// File: rtl/key_debounce_array_pkg.sv
// rtl/key_debounce_array_pkg.sv - shared channel states, timing defaults and width helper
// Contents:
//   key_state_e  per-channel debounce state (IDLE, PRESSING, PRESSED, RELEASING)
//   CNT_PER_US   default clk cycles per microsecond
//   CNT_PER_MS   default clk cycles per millisecond
//   width_for()  bits needed to hold a value 0..max_val (at least 1)
package key_pkg;

    // Bit 1 set means the key is debounced-pressed (PRESSED or RELEASING).
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESSING  = 2'b01,
        PRESSED   = 2'b11,
        RELEASING = 2'b10
    } key_state_e;

    localparam int CNT_PER_US = 20;
    localparam int CNT_PER_MS = 20000;

    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_array_if.sv
// rtl/key_debounce_array_if.sv - key pins and conditioned key event bundle
// Signals:
//   key_i            raw asynchronous key pins
//   key_level_o      debounced pressed level
//   press_pulse_o    one-cycle pulse on confirmed press
//   release_pulse_o  one-cycle pulse on confirmed release
//   long_pulse_o     one-cycle pulse when the hold reaches the long-press time
//   repeat_pulse_o   one-cycle auto-repeat pulse after a long press
//   any_press_o      OR of press_pulse_o
// Modports: master = conditioner side, slave = pin driver / event consumer side.
interface key_debounce_array_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_i;
    logic [N_KEYS-1:0] key_level_o;
    logic [N_KEYS-1:0] press_pulse_o;
    logic [N_KEYS-1:0] release_pulse_o;
    logic [N_KEYS-1:0] long_pulse_o;
    logic [N_KEYS-1:0] repeat_pulse_o;
    logic              any_press_o;

    modport master (
        input  key_i,
        output key_level_o, press_pulse_o, release_pulse_o,
               long_pulse_o, repeat_pulse_o, any_press_o
    );

    modport slave (
        output key_i,
        input  key_level_o, press_pulse_o, release_pulse_o,
               long_pulse_o, repeat_pulse_o, any_press_o
    );
endinterface

// File: rtl/key_debounce_array_channel.sv
// rtl/key_debounce_array_channel.sv - one key: synchroniser, debounce FSM, hold/repeat timing
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick            shared one-cycle millisecond strobe
//   key_raw         raw asynchronous pin
//   key_level       debounced pressed level
//   press_pulse     confirmed press
//   release_pulse   confirmed release
//   long_pulse      hold reached LONG_MS
//   repeat_pulse    every REPEAT_MS after the long press
module key_channel #(
    parameter int ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int PRESS_CYC   = 40000,
    parameter int RELEASE_CYC = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    import key_pkg::*;

    localparam int FILT_MAX = (PRESS_CYC > RELEASE_CYC) ? PRESS_CYC : RELEASE_CYC;
    localparam int FILT_W   = width_for(FILT_MAX);
    localparam int HOLD_W   = width_for(LONG_MS);
    localparam int REP_W    = width_for(REPEAT_MS);

    localparam logic [FILT_W-1:0] PRESS_LAST = FILT_W'(PRESS_CYC - 1);
    localparam logic [FILT_W-1:0] REL_LAST   = FILT_W'(RELEASE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_PRE   = HOLD_W'((LONG_MS > 0) ? LONG_MS - 1 : 0);
    localparam logic [REP_W-1:0]  REP_LAST   = REP_W'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
    localparam logic              LONG_EN    = (LONG_MS != 0);
    localparam logic              REP_EN     = (LONG_MS != 0) && (REPEAT_MS != 0);
    localparam logic              INACTIVE   = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;

    key_state_e        state_q, state_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              press_d, release_d, long_d, repeat_d;
    logic              hold_run;

    // Reset loads the idle pin level so leaving reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INACTIVE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
        end
    end

    assign act = sync_q[SYNC_STAGES-1] ^ INACTIVE;

    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        hold_run  = 1'b0;

        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = PRESSING;
                    filt_d  = '0;
                end
            end
            PRESSING: begin
                if (!act) begin
                    state_d = IDLE;
                end else if (filt_q < PRESS_LAST) begin
                    filt_d = filt_q + 1'b1;
                end else begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                    rep_d   = '0;
                end
            end
            PRESSED: begin
                hold_run = 1'b1;
                if (!act) begin
                    state_d = RELEASING;
                    filt_d  = '0;
                end
            end
            RELEASING: begin
                // Bounce back to PRESSED keeps the hold timing running.
                if (act) begin
                    state_d  = PRESSED;
                    hold_run = 1'b1;
                end else if (filt_q < REL_LAST) begin
                    filt_d   = filt_q + 1'b1;
                    hold_run = 1'b1;
                end else begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rep_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hold saturates at LONG_MS; from then on the repeat counter takes over,
        // so long and repeat can never fire on the same tick.
        if (hold_run && tick && LONG_EN) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
                long_d = (hold_q == HOLD_PRE);
            end else if (REP_EN) begin
                if (rep_q == REP_LAST) begin
                    rep_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            filt_q        <= '0;
            hold_q        <= '0;
            rep_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state_q       <= state_d;
            filt_q        <= filt_d;
            hold_q        <= hold_d;
            rep_q         <= rep_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
        end
    end

    assign key_level = (state_q == PRESSED) || (state_q == RELEASING);

endmodule

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - N-channel push-button conditioner with long press and auto-repeat
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   kif   key_debounce_array_if.master: key_i in; level, press, release,
//         long, repeat pulses and any_press out
module key_debounce_array #(
    parameter int N_KEYS      = 4,
    parameter int ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int PRESS_CYC   = 40000,
    parameter int RELEASE_CYC = 20,
    parameter int CNT_PER_MS  = key_pkg::CNT_PER_MS,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    key_debounce_array_if.master    kif
);
    import key_pkg::*;

    if (PRESS_CYC < 1) begin : g_chk_press
        $error("PRESS_CYC must be >= 1");
    end
    if (RELEASE_CYC < 1) begin : g_chk_release
        $error("RELEASE_CYC must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (CNT_PER_MS < 2) begin : g_chk_tick
        $error("CNT_PER_MS must be >= 2");
    end

    localparam int TICK_W = width_for(CNT_PER_MS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CNT_PER_MS - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;

    // Free-running and shared; key activity never realigns it, which is the
    // source of the up-to-one-ms jitter on long/repeat timing.
    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .SYNC_STAGES (SYNC_STAGES),
            .PRESS_CYC   (PRESS_CYC),
            .RELEASE_CYC (RELEASE_CYC),
            .LONG_MS     (LONG_MS),
            .REPEAT_MS   (REPEAT_MS)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .key_raw       (kif.key_i[i]),
            .key_level     (kif.key_level_o[i]),
            .press_pulse   (kif.press_pulse_o[i]),
            .release_pulse (kif.release_pulse_o[i]),
            .long_pulse    (kif.long_pulse_o[i]),
            .repeat_pulse  (kif.repeat_pulse_o[i])
        );
    end

    // Press pulses are already registered, so the OR is aligned with them.
    assign kif.any_press_o = |kif.press_pulse_o;

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - directed bench for key_debounce_array
module tb_key_debounce_array;
    localparam int N     = 4;
    localparam int SYNC  = 2;
    localparam int PRESS = 40;
    localparam int REL   = 4;
    localparam int CPM   = 10;
    localparam int LONG  = 3;
    localparam int REP   = 2;

    logic clk = 1'b0;
    logic rst;

    key_debounce_array_if #(.N_KEYS(N)) kif ();

    key_debounce_array #(
        .N_KEYS      (N),
        .ACTIVE_LOW  (1),
        .SYNC_STAGES (SYNC),
        .PRESS_CYC   (PRESS),
        .RELEASE_CYC (REL),
        .CNT_PER_MS  (CPM),
        .LONG_MS     (LONG),
        .REPEAT_MS   (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic bad;
        logic overlap;
        int   n;
        int   long_at;
        int   long_n;
        int   rep_n;
        int   rep_at [3];

        rst       = 1'b1;
        kif.key_i = 4'hF;
        repeat (3) step();
        chk("rst_level",   kif.key_level_o,     0);
        chk("rst_press",   kif.press_pulse_o,   0);
        chk("rst_release", kif.release_pulse_o, 0);
        chk("rst_long",    kif.long_pulse_o,    0);
        chk("rst_repeat",  kif.repeat_pulse_o,  0);
        chk("rst_any",     kif.any_press_o,     0);
        rst = 1'b0;

        // Clean press on ch0: next posedge is edge 0, pulse follows edge 42.
        kif.key_i[0] = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < SYNC + PRESS; k++) begin
            step();
            bad |= (|kif.press_pulse_o) | kif.any_press_o | (|kif.key_level_o);
        end
        chk("press0_early", bad, 0);
        step();
        chk("press0_pulse", kif.press_pulse_o, 4'b0001);
        chk("press0_any",   kif.any_press_o,   1);
        chk("press0_level", kif.key_level_o,   4'b0001);
        step();
        chk("press0_single", kif.press_pulse_o, 0);
        chk("any_single",    kif.any_press_o,   0);
        chk("press0_hold",   kif.key_level_o,   4'b0001);

        // Glitch on ch1: 30 active cycles never confirm.
        kif.key_i[1] = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (k == 30) kif.key_i[1] = 1'b1;
            step();
            bad |= kif.press_pulse_o[1] | kif.release_pulse_o[1] | kif.long_pulse_o[1]
                 | kif.repeat_pulse_o[1] | kif.key_level_o[1];
        end
        chk("glitch_ch1", bad, 0);

        // Release bounce on ch0: 3 high cycles then low again.
        kif.key_i[0] = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) kif.key_i[0] = 1'b0;
            step();
            bad |= kif.release_pulse_o[0] | ~kif.key_level_o[0];
        end
        chk("bounce_no_release", bad, 0);

        // Real release: pulse follows edge SYNC+REL counted from the high edge.
        kif.key_i[0] = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < SYNC + REL; k++) begin
            step();
            bad |= kif.release_pulse_o[0] | ~kif.key_level_o[0];
        end
        chk("release0_early", bad, 0);
        step();
        chk("release0_pulse", kif.release_pulse_o, 4'b0001);
        chk("release0_level", kif.key_level_o,     4'b0000);
        step();
        chk("release0_single", kif.release_pulse_o, 0);

        // Long press and repeat on ch2.
        kif.key_i[2] = 1'b0;
        n = 0;
        while (!kif.press_pulse_o[2] && n < 60) begin
            step();
            n++;
        end
        chk("press2_seen", kif.press_pulse_o[2], 1);
        long_at = -1;
        long_n  = 0;
        rep_n   = 0;
        overlap = 1'b0;
        rep_at  = '{-1, -1, -1};
        for (int c = 1; c <= 130; c++) begin
            step();
            if (kif.long_pulse_o[2]) begin
                long_n++;
                if (long_at < 0) long_at = c;
            end
            if (kif.repeat_pulse_o[2]) begin
                if (rep_n < 3) rep_at[rep_n] = c;
                rep_n++;
            end
            overlap |= kif.long_pulse_o[2] & kif.repeat_pulse_o[2];
        end
        chk("long2_count",   long_n, 1);
        chk("long2_window",  (long_at >= (LONG-1)*CPM+1) && (long_at <= LONG*CPM), 1);
        chk("repeat2_first", rep_at[0], long_at + REP*CPM);
        chk("repeat2_second", rep_at[1], long_at + 2*REP*CPM);
        chk("repeat2_third", rep_at[2], long_at + 3*REP*CPM);
        chk("long_repeat_overlap", overlap, 0);

        kif.key_i[2] = 1'b1;
        n = 0;
        while (!kif.release_pulse_o[2] && n < 20) begin
            step();
            n++;
        end
        chk("release2_seen", kif.release_pulse_o[2], 1);
        chk("release2_no_long", kif.long_pulse_o[2], 0);
        bad = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            bad |= kif.long_pulse_o[2] | kif.repeat_pulse_o[2] | kif.press_pulse_o[2]
                 | kif.key_level_o[2];
        end
        chk("after_release2_quiet", bad, 0);

        // Simultaneous press on ch1 and ch3.
        kif.key_i[1] = 1'b0;
        kif.key_i[3] = 1'b0;
        n = 0;
        while (!kif.any_press_o && n < 60) begin
            step();
            n++;
        end
        chk("simul_press", kif.press_pulse_o, 4'b1010);
        chk("simul_any",   kif.any_press_o,   1);
        step();
        chk("simul_any_single", kif.any_press_o, 0);

        // Reset while ch0/ch1/ch3 are pressed.
        kif.key_i[0] = 1'b0;
        n = 0;
        while (!kif.press_pulse_o[0] && n < 60) begin
            step();
            n++;
        end
        chk("press0_again", kif.press_pulse_o[0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_level",   kif.key_level_o,     0);
        chk("midrst_release", kif.release_pulse_o, 0);
        chk("midrst_press",   kif.press_pulse_o,   0);
        chk("midrst_long",    kif.long_pulse_o | kif.repeat_pulse_o, 0);
        // The first edge after the reset edge is edge 0 of the new press.
        n = 0;
        bad = 1'b0;
        while (!kif.press_pulse_o[0] && n < 60) begin
            step();
            n++;
            bad |= kif.release_pulse_o[0];
        end
        chk("repress_latency", n, SYNC + PRESS + 1);
        chk("repress_pattern", kif.press_pulse_o, 4'b1011);
        chk("midrst_no_release", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
